// File: rtl/fp_denorm_norm80_pkg.sv
// Shared FP80 constants, pre-normalizer state encoding and the normalized-operand bundle.
package fp80Pkg;

  localparam int EMSB  = 14;
  localparam int FMSB  = 63;
  localparam int XEMSB = EMSB + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fp80_norm_state_t;

  // exp is signed two's complement so denormals can rebase below 1.
  typedef struct packed {
    logic             sgn;
    logic [XEMSB:0]   exp;
    logic [FMSB+1:0]  fract;
    logic             zero;
    logic             inf;
    logic             nan;
    logic             denorm;
  } FP80N;

endpackage

// File: rtl/fp_denorm_norm80_lzc.sv
// Leading-zero count over a W-bit window, plus an all-zero flag.
module fp80_lzc_window #(
  parameter  int W  = 8,
  localparam int CW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  win,
  output logic [CW-1:0] cnt,
  output logic          all_zero
);

  // Scan upward so the most significant set bit is the last one to write cnt.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      if (win[i]) cnt = CW'(W - 1 - i);
    end
  end

  assign all_zero = ~|win;

endmodule

// File: rtl/fp_denorm_norm80.sv
// Iterative FP80 pre-normalizer. Define FP80_DENORM_EN to build the denormal shifter;
// without it denormals flush to signed zero with bypass latency.
module fp_denorm_norm80
  import fp80Pkg::*;
#(
  parameter int SHIFT_STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sgn,
  input  logic [EMSB:0]    exp,
  input  logic [FMSB+1:0]  fract,
  input  logic             xz,
  input  logic             mz,
  input  logic             inf,
  input  logic             nan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             o_sgn,
  output logic [XEMSB:0]   o_exp,
  output logic [FMSB+1:0]  o_fract,
  output logic             o_zero,
  output logic             o_inf,
  output logic             o_nan,
  output logic             o_denorm,
  output fp80_norm_state_t dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready & ce.
  // in_ready depends only on state and ce; out_valid is held until taken.

  fp80_norm_state_t state_q, state_d;
  FP80N             res_q;
  logic             valid_q;
  logic             accept;
  logic             is_denorm;

  assign in_ready  = (state_q == IDLE) & ce;
  assign accept    = in_valid & in_ready;
  assign is_denorm = xz & ~mz & ~inf & ~nan;

`ifdef FP80_DENORM_EN
  localparam int             CW     = (SHIFT_STEP > 1) ? $clog2(SHIFT_STEP) : 1;
  localparam logic [XEMSB:0] STEP_X = (XEMSB+1)'(SHIFT_STEP);

  logic [CW-1:0]  lz_cnt;
  logic           win_zero;
  logic [XEMSB:0] lz_x;

  fp80_lzc_window #(.W(SHIFT_STEP)) u_lzc (
    .win      (res_q.fract[FMSB+1 -: SHIFT_STEP]),
    .cnt      (lz_cnt),
    .all_zero (win_zero)
  );

  assign lz_x = {{(XEMSB+1-CW){1'b0}}, lz_cnt};
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef FP80_DENORM_EN
          state_d = is_denorm ? SHIFT : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef FP80_DENORM_EN
      SHIFT: if (!win_zero) state_d = DONE;
`endif
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else if (ce) begin
      state_q <= state_d;
      valid_q <= (state_d == DONE);
      if (accept) begin
        res_q.sgn <= sgn;
        if (is_denorm) begin
          res_q.inf    <= 1'b0;
          res_q.nan    <= 1'b0;
          res_q.denorm <= 1'b1;
`ifdef FP80_DENORM_EN
          // Start at +1 so the final exponent is 1 - leading zeros.
          res_q.exp    <= (XEMSB+1)'(1);
          res_q.fract  <= fract;
          res_q.zero   <= 1'b0;
`else
          res_q.exp    <= '0;
          res_q.fract  <= '0;
          res_q.zero   <= 1'b1;
`endif
        end else begin
          res_q.exp    <= {1'b0, exp};
          res_q.fract  <= fract;
          res_q.zero   <= xz & mz;
          res_q.inf    <= inf;
          res_q.nan    <= nan;
          res_q.denorm <= 1'b0;
        end
      end
`ifdef FP80_DENORM_EN
      else if (state_q == SHIFT) begin
        if (win_zero) begin
          res_q.fract <= res_q.fract << SHIFT_STEP;
          res_q.exp   <= res_q.exp - STEP_X;
        end else begin
          res_q.fract <= res_q.fract << lz_cnt;
          res_q.exp   <= res_q.exp - lz_x;
        end
      end
`endif
    end
  end

  assign out_valid = valid_q;
  assign o_sgn     = res_q.sgn;
  assign o_exp     = res_q.exp;
  assign o_fract   = res_q.fract;
  assign o_zero    = res_q.zero;
  assign o_inf     = res_q.inf;
  assign o_nan     = res_q.nan;
  assign o_denorm  = res_q.denorm;
  assign dbg_state = state_q;

endmodule
